// File: rtl/dcache1_wb_queue_pkg.sv
// Shared sizing and handshake state encoding for the dcache1 writeback (eviction) queue.
package dcache1_wb_queue_pkg;

    localparam int DC1WBQ_DEPTH = 4;
    localparam int DC1WBQ_AW    = 37;

    typedef enum logic [1:0] {
        DC1WBQ_IDLE = 2'd0,
        DC1WBQ_REQ  = 2'd1,
        DC1WBQ_WAIT = 2'd2
    } dc1wbq_state_e;

endpackage

// File: rtl/dcache1_wbq_cam.sv
// Parallel address comparator: one equality check per queue entry, gated by a per-entry mask.
module dcache1_wbq_cam
    import dcache1_wb_queue_pkg::*;
#(
    parameter int DEPTH = DC1WBQ_DEPTH,
    parameter int AW    = DC1WBQ_AW
) (
    input  logic [DEPTH*AW-1:0] entries,
    input  logic [DEPTH-1:0]    mask,
    input  logic [AW-1:0]       key,
    output logic [DEPTH-1:0]    match
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = mask[i] & (entries[i*AW +: AW] == key);
    end

endmodule

// File: rtl/dcache1_wb_queue.sv
// Victim-line eviction queue: captures refill victims, issues them in order to L2 over
// req/ack/done, and keeps every entry CAM-visible until its writeback is done.
module dcache1_wb_queue
    import dcache1_wb_queue_pkg::*;
#(
    parameter int DEPTH = DC1WBQ_DEPTH,
    parameter int AW    = DC1WBQ_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic          wb_valid,
    output logic          full,
    output logic          ovf_err,
    output logic          l2_req,
    output logic [AW-1:0] l2_addr,
    input  logic          l2_ack,
    input  logic          l2_done,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH - 1);

    logic [AW-1:0]       entry_addr [DEPTH];
    logic [DEPTH*AW-1:0] entry_flat;
    logic [DEPTH-1:0]    entry_vld;
    logic [DEPTH-1:0]    issued_mask;
    logic [DEPTH-1:0]    merge_match;
    logic [DEPTH-1:0]    chk_match;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic                ovf_q;
    logic                push;
    logic                merge;
    logic                pop;
    logic                alloc;
    logic                drop;
    dc1wbq_state_e       state;
    dc1wbq_state_e       state_next;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign entry_flat[i*AW +: AW] = entry_addr[i];
    end

    // Once the head is in WAIT, L2 may already hold its data, so it must not absorb merges.
    always_comb begin
        issued_mask = '0;
        if (state == DC1WBQ_WAIT) begin
            issued_mask[head] = 1'b1;
        end
    end

    dcache1_wbq_cam #(.DEPTH(DEPTH), .AW(AW)) u_merge_cam (
        .entries (entry_flat),
        .mask    (entry_vld & ~issued_mask),
        .key     (wb_addr),
        .match   (merge_match)
    );

    dcache1_wbq_cam #(.DEPTH(DEPTH), .AW(AW)) u_chk_cam (
        .entries (entry_flat),
        .mask    (entry_vld),
        .key     (chk_addr),
        .match   (chk_match)
    );

    assign push  = wb_en & wb_valid;
    assign merge = |merge_match;
    assign pop   = (state == DC1WBQ_WAIT) & l2_done;
    // A pop on a full queue frees the very slot the tail is about to write.
    assign alloc = push & ~merge & ((count != CNT_MAX) | pop);
    assign drop  = push & ~merge & (count == CNT_MAX) & ~pop;
    assign count_next = count + CW'(alloc) - CW'(pop);

    // NOTE: every output and next-state variable gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        l2_req     = 1'b0;
        l2_addr    = '0;
        unique case (state)
            DC1WBQ_IDLE: begin
                if (count != '0) state_next = DC1WBQ_REQ;
            end
            DC1WBQ_REQ: begin
                l2_req  = 1'b1;
                l2_addr = entry_addr[head];
                if (l2_ack) state_next = DC1WBQ_WAIT;
            end
            DC1WBQ_WAIT: begin
                if (l2_done) state_next = (count != CW'(1)) ? DC1WBQ_REQ : DC1WBQ_IDLE;
            end
            default: state_next = DC1WBQ_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(negedge clk) begin
        if (rst) begin
            state <= DC1WBQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            entry_vld <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (pop) begin
                entry_vld[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            // Placed after the pop so a same-slot push/pop leaves the entry occupied.
            if (alloc) begin
                entry_vld[tail] <= 1'b1;
                tail            <= tail + PW'(1);
            end
            count <= count_next;
            if (drop) ovf_q <= 1'b1;
        end
    end

    // NOTE: address storage has no reset; entry_vld alone decides whether a slot is meaningful.
    always_ff @(negedge clk) begin
        if (alloc) begin
            entry_addr[tail] <= wb_addr;
        end
    end

    assign full    = (count >= CNT_FULL);
    assign ovf_err = ovf_q;
    assign chk_hit = |chk_match;

endmodule
